// File: rtl/arith_pkg.sv
// Shared arithmetic-section definitions: widths and
// the divider state encoding.
package arith_pkg;

  localparam int N  = 3;
  localparam int QW = 2 * N;
  localparam int CW = $clog2(QW + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/seq_div3_if.sv
// Start/busy/done handshake bundle for the
// sequential restoring divider.
interface seq_div3_if
  import arith_pkg::*;
#(
  parameter int N = arith_pkg::N
);

  logic           start;
  logic [2*N-1:0] A;
  logic [N-1:0]   B;
  logic [2*N-1:0] Q;
  logic [N-1:0]   R;
  logic           busy;
  logic           done;
  logic           dbz;

  modport master (
    output start, A, B,
    input  Q, R, busy, done, dbz
  );

  modport slave (
    input  start, A, B,
    output Q, R, busy, done, dbz
  );

endinterface

// File: rtl/seq_div3_step.sv
// One restoring-division step: shift in a dividend
// bit, trial-subtract the divisor, emit a quotient bit.
module div_step #(
  parameter int N = 3
) (
  input  logic [N:0]   rw_i,
  input  logic         bit_i,
  input  logic [N-1:0] bdiv_i,
  output logic [N:0]   rw_o,
  output logic         q_o
);

  logic [N:0] t;
  logic [N:0] b_ext;
  logic       unused_msb;

  // rw < bdiv between steps, so its top bit is always 0
  assign unused_msb = rw_i[N];

  assign t     = {rw_i[N-1:0], bit_i};
  assign b_ext = {1'b0, bdiv_i};
  assign q_o   = (t >= b_ext);
  assign rw_o  = q_o ? (t - b_ext) : t;

endmodule

// File: rtl/seq_div3.sv
// Iterative restoring divider, 2N-bit dividend by
// N-bit divisor, one quotient bit per cycle.
module seq_div3
  import arith_pkg::*;
#(
  parameter int N = arith_pkg::N
) (
  input  logic       clk,
  input  logic       rst,
  seq_div3_if.slave  bus
);

  localparam int LQW = 2 * N;
  localparam int LCW = $clog2(LQW + 1);

  state_e           state_q;
  logic [N:0]       rw_q;
  logic [LQW-1:0]   qw_q;
  logic [N-1:0]     bdiv_q;
  logic [LCW-1:0]   cnt_q;
  logic [LQW-1:0]   q_q;
  logic [N-1:0]     r_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;

  logic [N:0]       rw_d;
  logic             qbit_d;
  logic [LQW-1:0]   qw_d;

  div_step #(.N(N)) u_step (
    .rw_i   (rw_q),
    .bit_i  (qw_q[LQW-1]),
    .bdiv_i (bdiv_q),
    .rw_o   (rw_d),
    .q_o    (qbit_d)
  );

  assign qw_d = {qw_q[LQW-2:0], qbit_d};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rw_q    <= '0;
      qw_q    <= '0;
      bdiv_q  <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            qw_q   <= bus.A;
            bdiv_q <= bus.B;
            rw_q   <= '0;
            cnt_q  <= '0;
            if (bus.B != '0) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
              q_q     <= '1;
              r_q     <= '0;
              dbz_q   <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          rw_q  <= rw_d;
          qw_q  <= qw_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LCW'(LQW - 1)) begin
            q_q     <= qw_d;
            r_q     <= rw_d[N-1:0];
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.Q    = q_q;
  assign bus.R    = r_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dbz  = dbz_q;

endmodule

// File: tb/tb_seq_div3.sv
// Randomized and directed bench for seq_div3 against
// an arithmetic division reference.
module tb_seq_div3;
  import arith_pkg::*;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  seq_div3_if #(.N(3)) bus ();

  seq_div3 #(.N(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [5:0] a,
                    input logic [2:0] b);
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.A     = 6'($urandom);
    bus.B     = 3'($urandom);
  endtask

  task automatic wait_done(output int cyc,
                           output int bcnt);
    cyc  = 1;
    bcnt = 0;
    while (!bus.done && cyc < 20) begin
      if (bus.busy) bcnt++;
      @(negedge clk);
      cyc++;
    end
    if (!bus.done) chk("timeout", 0, 1);
    chk("busy_done", 32'(bus.busy), 0);
  endtask

  task automatic check_res(input logic [5:0] a,
                           input logic [2:0] b,
                           input int cyc,
                           input int bcnt);
    int eq, er, ed;
    if (b == 0) begin
      eq = 63; er = 0; ed = 1;
      chk("lat_dbz", cyc, 1);
      chk("busy_dbz", bcnt, 0);
    end else begin
      eq = a / b; er = a % b; ed = 0;
      chk("lat", cyc, 7);
      chk("busy_cnt", bcnt, 6);
      chk("golden", 32'(bus.Q) * b + bus.R, a);
      chk("r_lt_b", 32'(bus.R < b), 1);
    end
    chk("Q", bus.Q, eq);
    chk("R", bus.R, er);
    chk("dbz", bus.dbz, ed);
  endtask

  task automatic op(input logic [5:0] a,
                    input logic [2:0] b);
    int cyc, bcnt;
    go(a, b);
    wait_done(cyc, bcnt);
    check_res(a, b, cyc, bcnt);
  endtask

  initial begin
    int cyc, bcnt;
    logic [5:0] a, na;
    logic [2:0] b, nb;
    logic [5:0] hq;
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_Q", bus.Q, 0);
    chk("rst_R", bus.R, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_dbz", bus.dbz, 0);
    rst = 1'b0;
    @(negedge clk);

    op(63, 7);
    hq = bus.Q;
    @(negedge clk);
    chk("hold_done", bus.done, 0);
    chk("hold_Q", bus.Q, 9);
    chk("hold_R", bus.R, 0);
    op(45, 4);
    op(5, 7);
    op(63, 1);
    op(20, 0);
    @(negedge clk);

    // start during RUN must be dropped
    go(45, 4);
    @(negedge clk);
    bus.A = 63; bus.B = 7; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(cyc, bcnt);
    chk("ign_Q", bus.Q, 11);
    chk("ign_R", bus.R, 1);
    chk("ign_lat", cyc, 5);
    op(63, 7);
    @(negedge clk);

    // reset mid-run
    go(45, 4);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_Q", bus.Q, 0);
    chk("mid_R", bus.R, 0);
    chk("mid_busy", bus.busy, 0);
    chk("mid_done", bus.done, 0);
    chk("mid_dbz", bus.dbz, 0);
    chk("mid_state", 32'(dut.state_q), 32'(IDLE));
    for (int i = 0; i < 8; i++) begin
      chk("mid_nodone", bus.done, 0);
      @(negedge clk);
    end
    op(45, 4);

    // exhaustive back-to-back, start in each done cycle
    a = 0; b = 1;
    go(a, b);
    for (int k = 1; k <= 448; k++) begin
      wait_done(cyc, bcnt);
      check_res(a, b, cyc, bcnt);
      if (k < 448) begin
        na = 6'((k) / 7);
        nb = 3'((k) % 7 + 1);
        a = na; b = nb;
        go(a, b);
      end
    end
    @(negedge clk);

    // random, including zero divisors
    for (int k = 0; k < 150; k++) begin
      a = 6'($urandom);
      b = 3'($urandom);
      op(a, b);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
